// File: rtl/vga_digit_scheduler.sv
// Scans three 8-bit ports round-robin through one shared double-dabble converter
// and publishes all nine BCD digits together in a single commit.
module vga_digit_scheduler #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          CHANGE_ONLY = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  port0_i,
    input  logic [7:0]  port1_i,
    input  logic [7:0]  port2_i,
    input  logic        force_i,
    output logic [11:0] hundreds_o,
    output logic [11:0] tens_o,
    output logic [11:0] ones_o,
    output logic        update_o,
    output logic        busy_o
);
    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_STORE, S_COMMIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_pend_q, tick_pend_d;
    logic          force_pend_q, force_pend_d;
    logic [1:0]    idx_q, idx_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [19:0]   sr_q, sr_d;
    logic [23:0]   snap_q, snap_d;
    logic [23:0]   last_q, last_d;
    logic [11:0]   stage_h_q, stage_h_d, stage_t_q, stage_t_d, stage_o_q, stage_o_d;
    logic [11:0]   hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic          update_q, update_d;

    logic          tick;
    logic          start;
    logic          forced;
    logic [23:0]   snap_now;
    logic [19:0]   sr_adj;

    assign tick     = (cnt_q == TC);
    assign forced   = force_i | force_pend_q;
    assign start    = tick | tick_pend_q | forced;
    assign snap_now = {port2_i, port1_i, port0_i};

    // Add-3 correction on the three BCD nibbles before each shift.
    always_comb begin
        sr_adj = sr_q;
        if (sr_q[11:8]  >= 4'd5) sr_adj[11:8]  = sr_q[11:8]  + 4'd3;
        if (sr_q[15:12] >= 4'd5) sr_adj[15:12] = sr_q[15:12] + 4'd3;
        if (sr_q[19:16] >= 4'd5) sr_adj[19:16] = sr_q[19:16] + 4'd3;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = tick ? '0 : cnt_q + 1'b1;
        tick_pend_d  = tick_pend_q | tick;
        force_pend_d = force_pend_q | force_i;
        idx_d        = idx_q;
        bcnt_d       = bcnt_q;
        sr_d         = sr_q;
        snap_d       = snap_q;
        last_d       = last_q;
        stage_h_d    = stage_h_q;
        stage_t_d    = stage_t_q;
        stage_o_d    = stage_o_q;
        hund_d       = hund_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        update_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tick_pend_d  = 1'b0;
                    force_pend_d = 1'b0;
                    snap_d       = snap_now;
                    if (!(CHANGE_ONLY && !forced && (snap_now == last_q))) begin
                        sr_d    = {12'b0, port0_i};
                        idx_d   = 2'd0;
                        bcnt_d  = 3'd0;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                sr_d   = {sr_adj[18:0], 1'b0};
                bcnt_d = bcnt_q + 3'd1;
                if (bcnt_q == 3'd7) state_d = S_STORE;
            end
            S_STORE: begin
                stage_h_d[{idx_q, 2'b00} +: 4] = sr_q[19:16];
                stage_t_d[{idx_q, 2'b00} +: 4] = sr_q[15:12];
                stage_o_d[{idx_q, 2'b00} +: 4] = sr_q[11:8];
                if (idx_q != 2'd2) begin
                    idx_d   = idx_q + 2'd1;
                    sr_d    = {12'b0, (idx_q == 2'd0) ? snap_q[15:8] : snap_q[23:16]};
                    bcnt_d  = 3'd0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                hund_d   = stage_h_q;
                tens_d   = stage_t_q;
                ones_d   = stage_o_q;
                last_d   = snap_q;
                update_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tick_pend_q  <= 1'b0;
            force_pend_q <= 1'b0;
            idx_q        <= '0;
            bcnt_q       <= '0;
            sr_q         <= '0;
            snap_q       <= '0;
            last_q       <= '0;
            stage_h_q    <= '0;
            stage_t_q    <= '0;
            stage_o_q    <= '0;
            hund_q       <= '0;
            tens_q       <= '0;
            ones_q       <= '0;
            update_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tick_pend_q  <= tick_pend_d;
            force_pend_q <= force_pend_d;
            idx_q        <= idx_d;
            bcnt_q       <= bcnt_d;
            sr_q         <= sr_d;
            snap_q       <= snap_d;
            last_q       <= last_d;
            stage_h_q    <= stage_h_d;
            stage_t_q    <= stage_t_d;
            stage_o_q    <= stage_o_d;
            hund_q       <= hund_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            update_q     <= update_d;
        end
    end

    assign hundreds_o = hund_q;
    assign tens_o     = tens_q;
    assign ones_o     = ones_q;
    assign update_o   = update_q;
    assign busy_o     = (state_q != S_IDLE);
endmodule

// File: tb/tb_vga_digit_scheduler.sv
// Directed bench for vga_digit_scheduler: scan timing, skip/force, pending merge, reset abort.
module tb_vga_digit_scheduler;
    localparam int DIV = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  p0 = '0, p1 = '0, p2 = '0;
    logic        frc = 1'b0;
    logic [11:0] hundreds, tens, ones;
    logic        update, busy;

    int tests = 0;
    int fails = 0;
    int m_cnt = 0;

    logic [127:0] bv, uv, bexp;
    logic [11:0]  o29, o58;
    logic         any_b, any_u;

    vga_digit_scheduler #(.REFRESH_DIV(DIV), .CHANGE_ONLY(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .port0_i(p0), .port1_i(p1), .port2_i(p2),
        .force_i(frc),
        .hundreds_o(hundreds), .tens_o(tens), .ones_o(ones),
        .update_o(update), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Reference tick counter, free-running like the spec describes.
    always @(posedge clk) begin
        if (rst) m_cnt <= 0;
        else     m_cnt <= (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic watch_quiet(input int n, output logic b, output logic u);
        b = 1'b0;
        u = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            b = b | busy;
            u = u | update;
        end
    endtask

    initial begin
        // Reset and idle with zero ports
        repeat (3) @(negedge clk);
        check("rst_hundreds", hundreds, 12'h000);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        check("rst_tens", tens, 12'h000);
        check("rst_ones", ones, 12'h000);
        check("rst_update", update, 1'b0);
        watch_quiet(80, any_b, any_u);
        check("zero_tick_busy", any_b, 1'b0);
        check("zero_tick_update", any_u, 1'b0);

        // Forced scan of 255/0/128 with exact timing
        bv = '0; uv = '0;
        bv[0] = busy; uv[0] = update;
        p0 = 8'd255; p1 = 8'd0; p2 = 8'd128; frc = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            if (k == 1) frc = 1'b0;
            bv[k] = busy; uv[k] = update;
        end
        check("A_busy_window", bv, 128'h1FFF_FFFE);
        check("A_update_pulse", uv, 128'h2000_0000);
        check("A_hundreds", hundreds, 12'h102);
        check("A_tens", tens, 12'h205);
        check("A_ones", ones, 12'h805);

        // 9/10/99 with port1 disturbed mid-scan
        uv = '0;
        p0 = 8'd9; p1 = 8'd10; p2 = 8'd99; frc = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            if (k == 1) frc = 1'b0;
            if (k == 5) p1 = 8'd200;
            if (k == 20) p1 = 8'd10;
            uv[k] = update;
        end
        check("B_update_pulse", uv, 128'h2000_0000);
        check("B_ones", ones, 12'h909);
        check("B_tens", tens, 12'h910);
        check("B_hundreds", hundreds, 12'h000);

        // Periodic tick with unchanged ports is skipped
        for (int i = 0; i < 2 * DIV && m_cnt != DIV - 1; i++) @(negedge clk);
        check("C_tick_reached", m_cnt, DIV - 1);
        watch_quiet(40, any_b, any_u);
        check("C_skip_busy", any_b, 1'b0);
        check("C_skip_update", any_u, 1'b0);

        // Force with unchanged ports still scans
        uv = '0;
        frc = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            if (k == 1) frc = 1'b0;
            uv[k] = update;
        end
        check("C_force_update", uv, 128'h2000_0000);
        check("C_force_ones", ones, 12'h909);

        // Two forces during one scan merge into one extra scan
        bv = '0; uv = '0; bexp = '0;
        for (int k = 0; k <= 95; k++) bexp[k] = ((k >= 1 && k <= 28) || (k >= 30 && k <= 57));
        bv[0] = busy; uv[0] = update;
        frc = 1'b1;
        for (int k = 1; k <= 95; k++) begin
            @(negedge clk);
            frc = (k == 5 || k == 12);
            bv[k] = busy; uv[k] = update;
        end
        check("D_busy_window", bv, bexp);
        check("D_update_pulses", uv, (128'd1 << 29) | (128'd1 << 58));

        // Tick landing mid-scan with changed ports triggers a back-to-back scan
        for (int i = 0; i < 2 * DIV && m_cnt != DIV - 11; i++) @(negedge clk);
        check("E_phase_reached", m_cnt, DIV - 11);
        bv = '0; uv = '0; o29 = '0; o58 = '0;
        bv[0] = busy; uv[0] = update;
        p0 = 8'd1; p1 = 8'd2; p2 = 8'd3; frc = 1'b1;
        for (int k = 1; k <= 95; k++) begin
            @(negedge clk);
            if (k == 1) begin
                frc = 1'b0;
                p0 = 8'd4; p1 = 8'd5; p2 = 8'd6;
            end
            bv[k] = busy; uv[k] = update;
            if (k == 29) o29 = ones;
            if (k == 58) o58 = ones;
        end
        check("E_busy_window", bv, bexp);
        check("E_update_pulses", uv, (128'd1 << 29) | (128'd1 << 58));
        check("E_first_ones", o29, 12'h321);
        check("E_second_ones", o58, 12'h654);
        check("E_final_tens", tens, 12'h000);

        // Reset in the middle of a scan
        p0 = 8'd7; p1 = 8'd8; p2 = 8'd9; frc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) frc = 1'b0;
            if (k == 15) rst = 1'b1;
        end
        check("F_hundreds", hundreds, 12'h000);
        check("F_tens", tens, 12'h000);
        check("F_ones", ones, 12'h000);
        check("F_busy", busy, 1'b0);
        check("F_update", update, 1'b0);
        rst = 1'b0;
        watch_quiet(40, any_b, any_u);
        check("F_no_update_after", any_u, 1'b0);
        check("F_no_busy_after", any_b, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_digit_scheduler.md
Name: vga_digit_scheduler

Overview:
- Sequencer that turns the three 8-bit display ports into decimal digits for the VGA character screen.
- Uses one shared, iterative shift-add-3 (double-dabble) converter instead of three combinational converters.
- Scans the ports round-robin and publishes all nine digits in a single atomic commit, so the screen never shows a mix of old and new values.
- Sits between the CPU output ports and the VGA text renderer.

Parameters:
- REFRESH_DIV, 50000: clk cycles between periodic scan ticks; legal range ≥ 2.
- CHANGE_ONLY, 1: when 1, a tick whose port snapshot equals the last converted snapshot is skipped (no scan, no update pulse).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- port0  in  8  value 0
- port1  in  8  value 1
- port2  in  8  value 2
- force  in  1  one-cycle request: scan now, bypassing CHANGE_ONLY
- hundreds  out  12  hundreds digits; bits [4i+3:4i] = port i
- tens  out  12  tens digits, same packing
- ones  out  12  ones digits, same packing
- update  out  1  one-cycle pulse when new digits are committed
- busy  out  1  high while a scan is in progress

Behaviour:
- Clocking/reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: hundreds/tens/ones = 0, update = 0, busy = 0; tick counter, pending flags, index, staging and last snapshot all = 0.
- Reset mid-scan: the scan is aborted, staging is discarded, outputs read 0, and the FSM is in IDLE on the next cycle.
- Tick counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick = 1 in the cycle the count equals REFRESH_DIV-1.
  - Free-runs regardless of FSM state.
- Pending flags:
  - tick_pend is set by a tick and cleared when consumed in IDLE.
  - force_pend is set by force and cleared when consumed in IDLE.
  - Ticks/forces arriving while busy set the flag (one deep; multiple arrivals merge).
- FSM states: IDLE, SHIFT, STORE, COMMIT.
- IDLE, in cycle T:
  - Start condition is (tick | tick_pend | force | force_pend).
  - On start: snapshot {port2, port1, port0}.
  - Skip case: CHANGE_ONLY = 1, no force/force_pend, and snapshot == last snapshot → clear pending flags and stay in IDLE.
  - Otherwise: load the 20-bit shift register {12'b0, snap0}, idx = 0, bit count = 0, go to SHIFT. busy = 1 from T+1.
- SHIFT, 8 cycles:
  - Each cycle, in one combinational step: add 3 to every BCD nibble ≥ 5, then shift the whole register left by 1.
  - After the 8th shift, go to STORE.
- STORE, 1 cycle:
  - Write nibbles [19:16], [15:12], [11:8] into staging hundreds/tens/ones for idx.
  - If idx < 2: idx++, load {12'b0, snap[idx+1]}, go to SHIFT.
  - If idx == 2: go to COMMIT.
- COMMIT, 1 cycle:
  - Copy staging to the outputs and set last snapshot = snapshot.
  - update = 1 in the following cycle; busy returns to 0 in that same cycle; go to IDLE.
- Timing, for a start accepted in cycle T:
  - SHIFT runs T+1..T+8, T+10..T+17, T+19..T+26.
  - STORE at T+9, T+18, T+27; COMMIT at T+28.
  - New outputs and update are visible in cycle T+29.
  - busy is high T+1..T+28.
- Output stability: outputs change only at COMMIT and stay stable between commits. Port changes during a scan do not affect it (the snapshot is used).
- Pending after commit: if a flag is set at COMMIT, it is consumed in the IDLE cycle T+29 and the next scan starts immediately. It is still subject to the CHANGE_ONLY skip unless it is a force.
- Arithmetic: inputs are 0..255, so hundreds ≤ 2; every output nibble is always 0..9.
- Small REFRESH_DIV: values below 30 cause ticks during busy. These merge into tick_pend; back-to-back scans result and no ticks are lost beyond the merge.

Test Plan:
- Reset, then hold ports 0/0/0 with CHANGE_ONLY = 1 → all outputs 0; no update after the first tick (snapshot equals the reset snapshot).
- port0 = 255, port1 = 0, port2 = 128, force pulse at cycle T:
  - update pulses exactly at T+29; busy high T+1..T+28.
  - hundreds = 12'h102, tens = 12'h205, ones = 12'h805.
- Scan of 9/10/99 → ones = 12'h909, tens = 12'h910, hundreds = 12'h000; change port1 to 200 mid-scan → results still reflect 10.
- Unchanged ports with CHANGE_ONLY = 1 → periodic tick gives no busy and no update; force with unchanged ports → full scan and an update pulse.
- Tick or force asserted during busy → second scan starts in cycle T+29 and its update arrives at T+58. Two forces during one scan produce only one extra scan.
- rst asserted at T+15 of a scan (prior outputs nonzero) → next cycle outputs 0, busy 0, update 0. No update pulse until a new start.
